// File: rtl/dram_cmd_gen_if.sv
// Request-queue-to-command-generator bus: head-of-queue handshake in, DRAM commands out.
interface dram_cmd_gen_if;
  logic        req_valid;
  logic [34:0] req_data;
  logic        req_ready;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        req_err;

  modport master (
    output req_valid, req_data,
    input  req_ready, cmd_valid, cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col, req_err
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, cmd_valid, cmd_op, cmd_bg, cmd_bank, cmd_row, cmd_col, req_err
  );
endinterface

// File: rtl/dram_cmd_gen.sv
// Open-page DRAM command generator: one request in flight, ACT/RD/WR/PRE issued under
// per-bank precharge timing and a shared tRP/tRCD counter. T_RCD and T_RP must be >= 1.
module dram_cmd_gen #(
  parameter int unsigned T_RCD = 39,
  parameter int unsigned T_RP  = 39,
  parameter int unsigned T_RAS = 76,
  parameter int unsigned T_RTP = 18,
  parameter int unsigned T_WR  = 48,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  dram_cmd_gen_if.slave bus
);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StDecide     = 3'd1;
  localparam logic [2:0] StPre        = 3'd2;
  localparam logic [2:0] StWaitRp     = 3'd3;
  localparam logic [2:0] StActWaitRcd = 3'd4;
  localparam logic [2:0] StCol        = 3'd5;

  localparam logic [2:0] OpNop = 3'd0;
  localparam logic [2:0] OpAct = 3'd1;
  localparam logic [2:0] OpRd  = 3'd2;
  localparam logic [2:0] OpWr  = 3'd3;
  localparam logic [2:0] OpPre = 3'd4;

  // Counters hold "cycles remaining minus one" so a load of T at cycle c reads 0 at c+T.
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRcdM1  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] TRpM1   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] TRasM1  = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] TRtp    = CNT_W'(T_RTP);
  localparam logic [CNT_W-1:0] TWr     = CNT_W'(T_WR);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] t_cnt_q, t_cnt_d;
  logic [15:0]      open_q, open_d;
  logic [14:0]      open_row_q [16];
  logic [14:0]      open_row_d [16];
  logic [CNT_W-1:0] pre_cnt_q [16];
  logic [CNT_W-1:0] pre_cnt_d [16];
  logic             wr_q, wr_d;
  logic [1:0]       bg_q, bg_d, bank_q, bank_d;
  logic [14:0]      row_q, row_d;
  logic [9:0]       col_q, col_d;
  logic             err_q, err_d;

  logic [3:0]       idx;
  logic [CNT_W-1:0] cur_pre, rec_t;
  logic             do_act, do_pre, do_col;
  logic             unused_addr;

  assign idx           = {bg_q, bank_q};
  assign cur_pre       = pre_cnt_q[idx];
  assign rec_t         = wr_q ? TWr : TRtp;
  assign unused_addr   = ^bus.req_data[5:0];
  assign bus.req_ready = (state_q == StIdle);
  assign bus.req_err   = err_q;

  always_comb begin
    state_d    = state_q;
    t_cnt_d    = (t_cnt_q != '0) ? t_cnt_q - CntOne : '0;
    open_d     = open_q;
    open_row_d = open_row_q;
    for (int i = 0; i < 16; i++) begin
      pre_cnt_d[i] = (pre_cnt_q[i] != '0) ? pre_cnt_q[i] - CntOne : '0;
    end
    wr_d   = wr_q;
    bg_d   = bg_q;
    bank_d = bank_q;
    row_d  = row_q;
    col_d  = col_q;
    err_d  = 1'b0;
    do_act = 1'b0;
    do_pre = 1'b0;
    do_col = 1'b0;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OpNop;
    bus.cmd_bg    = '0;
    bus.cmd_bank  = '0;
    bus.cmd_row   = '0;
    bus.cmd_col   = '0;

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (bus.req_data[34:33] == 2'd3) begin
            err_d = 1'b1;
          end else begin
            wr_d    = (bus.req_data[34:33] == 2'd1);
            row_d   = bus.req_data[32:18];
            col_d   = {bus.req_data[17:10], 2'b00};
            bank_d  = bus.req_data[9:8];
            bg_d    = bus.req_data[7:6];
            state_d = StDecide;
          end
        end
      end
      StDecide: begin
        if (!open_q[idx]) begin
          do_act = 1'b1;
        end else if (open_row_q[idx] == row_q) begin
          do_col = 1'b1;
        end else if (cur_pre == '0) begin
          do_pre = 1'b1;
        end else begin
          state_d = StPre;
        end
      end
      StPre:        if (cur_pre == '0) do_pre = 1'b1;
      StWaitRp:     if (t_cnt_q == '0) do_act = 1'b1;
      StActWaitRcd: if (t_cnt_q == CntOne) state_d = StCol;
      StCol:        do_col = 1'b1;
      default:      state_d = StIdle;
    endcase

    if (do_act) begin
      bus.cmd_valid   = 1'b1;
      bus.cmd_op      = OpAct;
      bus.cmd_bg      = bg_q;
      bus.cmd_bank    = bank_q;
      bus.cmd_row     = row_q;
      open_d[idx]     = 1'b1;
      open_row_d[idx] = row_q;
      pre_cnt_d[idx]  = TRasM1;
      t_cnt_d         = TRcdM1;
      state_d         = (T_RCD > 1) ? StActWaitRcd : StCol;
    end

    if (do_pre) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OpPre;
      bus.cmd_bg    = bg_q;
      bus.cmd_bank  = bank_q;
      open_d[idx]   = 1'b0;
      t_cnt_d       = TRpM1;
      state_d       = StWaitRp;
    end

    if (do_col) begin
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = wr_q ? OpWr : OpRd;
      bus.cmd_bg     = bg_q;
      bus.cmd_bank   = bank_q;
      bus.cmd_col    = col_q;
      // Max rule keeps any longer pending precharge constraint intact.
      pre_cnt_d[idx] = ((cur_pre > rec_t) ? cur_pre : rec_t) - CntOne;
      state_d        = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      t_cnt_q <= '0;
      open_q  <= '0;
      for (int i = 0; i < 16; i++) begin
        open_row_q[i] <= '0;
        pre_cnt_q[i]  <= '0;
      end
      wr_q   <= 1'b0;
      bg_q   <= '0;
      bank_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_cnt_q    <= t_cnt_d;
      open_q     <= open_d;
      open_row_q <= open_row_d;
      pre_cnt_q  <= pre_cnt_d;
      wr_q       <= wr_d;
      bg_q       <= bg_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_dram_cmd_gen.sv
// Scoreboard bench for dram_cmd_gen: a deadline-based bank model predicts every command and
// error pulse with its cycle; a negedge monitor matches them against the DUT outputs.
module tb_dram_cmd_gen;

  localparam int T_RCD = 39;
  localparam int T_RP  = 39;
  localparam int T_RAS = 76;
  localparam int T_RTP = 18;
  localparam int T_WR  = 48;

  typedef struct {
    int cyc;
    int op;
    int bg;
    int bank;
    int row;
    int col;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   next_ready = 0;

  cmd_t exp_q[$];
  int   err_q[$];
  cmd_t mon_e;

  // Bank model: open flag, open row and earliest cycle a PRE is legal.
  bit m_open[16];
  int m_row[16];
  int m_pre_ok[16];

  dram_cmd_gen_if bus ();

  dram_cmd_gen #(
    .T_RCD(T_RCD),
    .T_RP (T_RP),
    .T_RAS(T_RAS),
    .T_RTP(T_RTP),
    .T_WR (T_WR),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void push_cmd(input int c, input int op, input int bg, input int bk,
                                   input int row, input int col);
    cmd_t e;
    e.cyc = c; e.op = op; e.bg = bg; e.bank = bk; e.row = row; e.col = col;
    exp_q.push_back(e);
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    exp_q.delete();
    err_q.delete();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0; m_row[i] = 0; m_pre_ok[i] = 0;
    end
    next_ready = 0;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (bus.req_ready !== 1'b1 || bus.cmd_valid !== 1'b0 || bus.cmd_op !== 3'd0 ||
        bus.cmd_bg !== 2'd0 || bus.cmd_bank !== 2'd0 || bus.cmd_row !== 15'd0 ||
        bus.cmd_col !== 10'd0 || bus.req_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b valid=%b op=%0d bg=%0d bank=%0d row=%0d col=%0d err=%b, expected ready=1 and all else 0",
               bus.req_ready, bus.cmd_valid, bus.cmd_op, bus.cmd_bg, bus.cmd_bank,
               bus.cmd_row, bus.cmd_col, bus.req_err);
    end
  endtask

  task automatic send(input int op, input longint addr, input int gap);
    int c, d, b, row, col, bg, bk, act, pre, cc;
    bit wr;
    while (cyc < next_ready) begin
      n_chk++;
      if (bus.req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL busy_ready @%0d: req_ready=%b, expected 0", cyc, bus.req_ready);
      end
      @(negedge clk);
    end
    repeat (gap) @(negedge clk);
    c = cyc;
    n_chk++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_ready @%0d: req_ready=%b, expected 1", c, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_data  = {2'(op), 33'(addr)};

    row = int'((addr >> 18) & 64'h7fff);
    col = int'((addr >> 10) & 64'hff) * 4;
    bk  = int'((addr >> 8) & 64'h3);
    bg  = int'((addr >> 6) & 64'h3);
    b   = bg * 4 + bk;
    d   = c + 1;
    if (op == 3) begin
      err_q.push_back(d);
      next_ready = d;
    end else begin
      act = -1;
      cc  = d;
      if (!m_open[b]) begin
        act = d;
      end else if (m_row[b] != row) begin
        pre = imax(d, m_pre_ok[b]);
        push_cmd(pre, 4, bg, bk, 0, 0);
        act = pre + T_RP;
      end
      if (act >= 0) begin
        push_cmd(act, 1, bg, bk, row, 0);
        m_open[b]   = 1'b1;
        m_row[b]    = row;
        m_pre_ok[b] = act + T_RAS;
        cc          = act + T_RCD;
      end
      wr = (op == 1);
      push_cmd(cc, wr ? 3 : 2, bg, bk, 0, col);
      m_pre_ok[b] = imax(m_pre_ok[b], cc + (wr ? T_WR : T_RTP));
      next_ready  = cc + 1;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Monitor: drop overdue expectations as missing, then match whatever the DUT shows now.
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_chk++; n_err++;
        $display("FAIL missing_cmd: op=%0d expected @%0d, not seen by %0d", exp_q[0].op,
                 exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      n_chk++;
      if (bus.cmd_valid === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          n_err++;
          $display("FAIL unexpected_cmd @%0d: op=%0d bg=%0d bank=%0d, expected none", cyc,
                   bus.cmd_op, bus.cmd_bg, bus.cmd_bank);
        end else begin
          mon_e = exp_q.pop_front();
          if (int'(bus.cmd_op) != mon_e.op || int'(bus.cmd_bg) != mon_e.bg ||
              int'(bus.cmd_bank) != mon_e.bank ||
              (mon_e.op == 1 && int'(bus.cmd_row) != mon_e.row) ||
              ((mon_e.op == 2 || mon_e.op == 3) && int'(bus.cmd_col) != mon_e.col)) begin
            n_err++;
            $display("FAIL cmd @%0d: got op=%0d bg=%0d bank=%0d row=%0d col=%0d, expected op=%0d bg=%0d bank=%0d row=%0d col=%0d",
                     cyc, bus.cmd_op, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col,
                     mon_e.op, mon_e.bg, mon_e.bank, mon_e.row, mon_e.col);
          end
        end
      end else if (bus.cmd_op !== 3'd0) begin
        n_err++;
        $display("FAIL idle_op @%0d: cmd_op=%0d with cmd_valid=%b, expected 0", cyc,
                 bus.cmd_op, bus.cmd_valid);
      end

      while (err_q.size() > 0 && err_q[0] < cyc) begin
        n_chk++; n_err++;
        $display("FAIL missing_err: expected @%0d, not seen by %0d", err_q[0], cyc);
        void'(err_q.pop_front());
      end
      if (bus.req_err === 1'b1) begin
        n_chk++;
        if (err_q.size() == 0 || err_q[0] != cyc) begin
          n_err++;
          $display("FAIL unexpected_err @%0d: req_err=1, expected 0", cyc);
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int     op, r, gap;
    longint addr;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    repeat (2) @(negedge clk);
    apply_reset();

    // Directed: closed bank, hit, miss with write recovery, other bank, illegal op.
    send(0, 64'h0_0004_0000, 0);
    send(1, 64'h0_0004_0400, 0);
    send(0, 64'h0_0008_0000, 0);
    send(0, 64'h0_0000_0100, 0);
    send(3, 64'h0_0000_0100, 0);
    send(0, 64'h0_0000_0100, 0);

    // Reset in the middle of tRCD, then the same row must be activated again.
    apply_reset();
    send(0, 64'h0_0004_0000, 0);
    while (cyc < 20) @(negedge clk);
    apply_reset();
    send(0, 64'h0_0004_0000, 0);

    for (int i = 0; i < 120; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      addr = (longint'($urandom_range(0, 3)) << 18) | (longint'($urandom_range(0, 255)) << 10) |
             (longint'($urandom_range(0, 3)) << 8) | (longint'($urandom_range(0, 3)) << 6) |
             longint'($urandom_range(0, 63));
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      send(op, addr, gap);
    end

    for (int i = 0; i < 400 && (exp_q.size() != 0 || err_q.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d commands and %0d errors outstanding, expected 0 and 0",
               exp_q.size(), err_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dram_cmd_gen.md
Name: dram_cmd_gen

Overview:
- Downstream stage of the 16-entry memory-controller request queue.
- Takes one request at a time from the head of the queue over a valid/ready handshake.
- Decodes the 33-bit address into bank group, bank, row and column.
- Issues ACT/RD/WR/PRE commands under an open-page policy, enforcing per-bank timing with cycle counters.

Parameters:
- T_RCD, 39, cycles from ACT to RD/WR on the same bank
- T_RP, 39, cycles from PRE to ACT on the same bank
- T_RAS, 76, minimum cycles from ACT to PRE on the same bank
- T_RTP, 18, minimum cycles from RD to PRE on the same bank
- T_WR, 48, minimum cycles from WR to PRE on the same bank (write recovery, counted from the WR command)
- CNT_W, 8, width of the timing counters; every T_* must be < 2**CNT_W

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  queue head valid
- req_data  in  35  {op[34:33], addr[32:0]}; op 0=read, 1=write, 2=ifetch, 3=illegal
- req_ready  out  1  block accepts the request this cycle
- cmd_valid  out  1  command issued this cycle
- cmd_op  out  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE
- cmd_bg  out  2  bank group
- cmd_bank  out  2  bank
- cmd_row  out  15  row (meaningful on ACT)
- cmd_col  out  10  column (meaningful on RD/WR)
- req_err  out  1  one-cycle pulse when an op=3 request is dropped

Behaviour:
- Address map: row=addr[32:18], col=addr[17:8], bank=addr[9:8]... no overlap; the exact map is: row=addr[32:18], col=addr[17:8] is NOT used — use col=addr[17:10]<<2 (col[9:2]=addr[17:10], col[1:0]=0), bank=addr[9:8], bg=addr[7:6], addr[5:0] ignored.
- Bank index = {bg, bank}, giving 16 banks.
- Per-bank state: open (1b), open_row (15b), pre_cnt (CNT_W).
- pre_cnt:
  - Decrements by 1 each cycle while nonzero.
  - On ACT it is loaded with T_RAS.
  - On RD it is loaded with max(pre_cnt, T_RTP); on WR with max(pre_cnt, T_WR).
  - A value V loaded at cycle c reads 0 at cycle c+V.
- Global counter t_cnt times T_RP and T_RCD for the in-flight request.
- Only one request is in flight. At most one command is issued per cycle. cmd_valid=0 implies cmd_op=0.
- FSM states: IDLE, DECIDE, PRE, WAIT_RP, ACT_WAIT_RCD, COL.
- IDLE:
  - req_ready=1 only in IDLE.
  - When req_valid&&req_ready, latch the fields and go to DECIDE.
  - If op=3: pulse req_err the next cycle, issue no command, return to IDLE.
- DECIDE (first command cycle, i.e. accept cycle + 1):
  - Bank open with row match (hit): issue RD (op 0/2) or WR (op 1) this cycle, then go to IDLE.
  - Bank closed: issue ACT this cycle, load t_cnt=T_RCD, go to ACT_WAIT_RCD.
  - Bank open with a different row (miss): go to PRE logic in this same cycle; issue PRE when pre_cnt==0, otherwise stay in PRE.
- PRE:
  - Issue PRE on the first cycle with pre_cnt==0.
  - Clear the bank's open flag, load t_cnt=T_RP, go to WAIT_RP.
- WAIT_RP: issue ACT when exactly T_RP cycles have elapsed since PRE, load t_cnt=T_RCD, go to ACT_WAIT_RCD.
- ACT_WAIT_RCD: issue RD/WR exactly T_RCD cycles after ACT, then go to IDLE.
- ACT sets open=1 and open_row=row.
- Turnaround: after RD/WR at cycle c, req_ready=1 at c+1, so the next request's first command is at c+2 at the earliest.
- Other banks' counters keep running during any wait.
- Reset (including mid-operation):
  - All banks closed, all counters 0, FSM to IDLE.
  - Outputs: req_ready=1, cmd_valid=0, cmd_op=0, cmd_bg/bank/row/col=0, req_err=0 in the first cycle after reset.
  - An in-flight request is dropped.
- Counter saturation: pre_cnt never wraps below 0. Loads use the max rule, so a later shorter constraint never shortens a pending one.

Test Plan:
- Reset, then at cycle 0 accept read addr 0x0_0004_0000 (row1, bg0, bank0, col0) -> ACT row1 at cycle 1; RD col0 at cycle 40; req_ready high at 41.
- Accept write 0x0_0004_0400 at cycle 41 (hit, col=4) -> WR at cycle 42, no ACT.
- Accept read 0x0_0008_0000 at cycle 43 (miss, row2):
  - pre_cnt from ACT@1 reaches 0 at 77; from WR@42 it reaches 0 at 90.
  - Expect PRE at 90, ACT row2 at 129, RD at 168.
- After the first scenario, accept read 0x100 (bank1, closed) -> ACT bank1 on the next cycle, unaffected by bank0 counters.
- Request with op=3 -> req_err pulse for one cycle, no cmd_valid, req_ready high the following cycle.
- Assert rst during ACT_WAIT_RCD (cycle 20 of scenario 1) -> cmd_valid=0, no RD. The next read to row1 issues ACT again, because the bank is closed.
